tri_nand_exerciser: RTL and testbench
=====================================

TRI_NAND_EXERCISER -- requirements
Module: tri_nand_exerciser

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2, meaning clocks allowed for gate outputs to settle after each vector change (legal range 1..15).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port start, input, 1, single-cycle request to run a full test sweep.
REQ-005 SHALL have ports A1,B1,C1,A2,B2,C2,A3,B3,C3, output, 1 each, stimulus to the three 3-input NAND gates under test.
REQ-006 SHALL have ports Y1,Y2,Y3, input, 1 each, responses from the gates under test (same clock domain, no synchronizer).
REQ-007 SHALL have port busy, output, 1, high while a sweep is in progress.
REQ-008 SHALL have port done, output, 1, high once a sweep has completed, held until next start or reset.
REQ-009 SHALL have port pass, output, 1, valid when done: 1 = all gates matched on all vectors.
REQ-010 SHALL have port fail_mask, output, 3, bit i-1 set = gate i mismatched on at least one vector.
REQ-011 SHALL have port first_err_vec, output, 3, index of first vector producing any mismatch; 0 if none.

Function
REQ-012 SHALL implement FSM states IDLE, SETTLE, CHECK, DONE.
REQ-013 SHALL use a 3-bit vector index vec; for vector vec, A1=A2=A3=vec[2], B1=B2=B3=vec[1], C1=C2=C3=vec[0].
REQ-014 SHALL drive all nine stimulus outputs low in IDLE and DONE.
REQ-015 SHALL, on start in IDLE or DONE: set vec=0, clear fail_mask, first_err_vec, pass, done, settle counter; enter SETTLE next cycle with vector 0 driven.
REQ-016 SHALL ignore start while in SETTLE or CHECK (no restart, no state change).
REQ-017 SHALL, in SETTLE, increment the settle counter each cycle and move to CHECK on the cycle the counter equals SETTLE_CYCLES-1.
REQ-018 SHALL, in CHECK, compare each Yi against expected ~(vec[2]&vec[1]&vec[0]) and OR mismatches into fail_mask (sticky).
REQ-019 SHALL capture first_err_vec=vec only on the first CHECK with any mismatch; later mismatches SHALL NOT overwrite it.
REQ-020 SHALL, in CHECK with vec<7, increment vec, clear settle counter, return to SETTLE; with vec=7 enter DONE (no wrap to 0 mid-sweep).
REQ-021 SHALL, on entering DONE, set done=1 and pass=1 iff final fail_mask (including vec=7 result) is 000.
REQ-022 SHALL assert busy exactly in SETTLE and CHECK; sweep length from start edge to done=1 is 8*(SETTLE_CYCLES+1)+1 clocks.
REQ-023 SHALL hold vector outputs stable for the full SETTLE and CHECK interval of each vector.
REQ-024 SHALL treat X/Z on Yi as mismatch in simulation (compare with case-inequality semantics not required in synthesis).

Reset
REQ-025 SHALL, on rst=1 at any time including mid-sweep, asynchronously force state IDLE, vec=0, settle counter=0, all stimulus outputs 0, busy=0, done=0, pass=0, fail_mask=000, first_err_vec=000.
REQ-026 SHALL ignore start while rst=1; first sweep may begin on the first rising edge after rst deasserts.

Verification
REQ-027 Correct gates (Yi = NAND of stimuli), SETTLE_CYCLES=2, start pulse -> busy for 24 cycles, done=1 at cycle 25, pass=1, fail_mask=000, first_err_vec=000.
REQ-028 Gate 2 stuck-at-1 -> done, pass=0, fail_mask=010, first_err_vec=111.
REQ-029 Gate 1 stuck-at-0 and gate 3 with inputs A/B swapped-irrelevant but C inverted -> fail_mask=101, first_err_vec=000.
REQ-030 Start pulsed again at cycle 10 of a sweep -> ignored; sweep completes at original cycle 25 with unchanged result.
REQ-031 rst asserted mid-sweep at vec=4 -> all outputs 0 immediately (before next edge); new start after release runs full sweep from vec=0.
REQ-032 Start while done=1 after a failing sweep, correct gates now -> done drops next cycle, fail_mask cleared, new sweep ends pass=1.

Source files
------------

// File: rtl/tri_nand_exerciser.sv
// Sweeps all eight input combinations through three 3-input NAND gates, waits a
// programmable settle time per vector and records which gates disagree with NAND.
module tri_nand_exerciser #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       A1,
  output logic       B1,
  output logic       C1,
  output logic       A2,
  output logic       B2,
  output logic       C2,
  output logic       A3,
  output logic       B3,
  output logic       C3,
  input  logic       Y1,
  input  logic       Y2,
  input  logic       Y3,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] fail_mask,
  output logic [2:0] first_err_vec
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  function automatic logic nand3_exp(input logic [2:0] v);
    return ~(v[2] & v[1] & v[0]);
  endfunction

  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] stim_q, stim_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] fail_mask_q, fail_mask_d;
  logic [2:0] first_err_q, first_err_d;
  logic [2:0] mismatch_s;

  // Case-inequality so an unknown response counts as a mismatch in simulation.
  always_comb begin
    mismatch_s    = 3'b000;
    mismatch_s[0] = (Y1 !== nand3_exp(vec_q));
    mismatch_s[1] = (Y2 !== nand3_exp(vec_q));
    mismatch_s[2] = (Y3 !== nand3_exp(vec_q));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) state_d = SETTLE;
        else       state_d = IDLE;
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) state_d = CHECK;
        else                      state_d = SETTLE;
      end
      CHECK: begin
        if (vec_q == 3'd7) state_d = DONE;
        else               state_d = SETTLE;
      end
      DONE: begin
        if (start) state_d = SETTLE;
        else       state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values, derived from the next state.
  always_comb begin
    vec_d       = vec_q;
    cnt_d       = cnt_q;
    fail_mask_d = fail_mask_q;
    first_err_d = first_err_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          vec_d       = 3'd0;
          cnt_d       = 4'd0;
          fail_mask_d = 3'b000;
          first_err_d = 3'd0;
        end else begin
          vec_d       = vec_q;
          cnt_d       = cnt_q;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
      end
      CHECK: begin
        fail_mask_d = fail_mask_q | mismatch_s;
        if ((fail_mask_q == 3'b000) && (mismatch_s != 3'b000)) begin
          first_err_d = vec_q;
        end else begin
          first_err_d = first_err_q;
        end
        if (vec_q != 3'd7) begin
          vec_d = vec_q + 3'd1;
          cnt_d = 4'd0;
        end else begin
          vec_d = vec_q;
          cnt_d = cnt_q;
        end
      end
      default: begin
        vec_d = 3'd0;
        cnt_d = 4'd0;
      end
    endcase
    busy_d = (state_d == SETTLE) || (state_d == CHECK);
    done_d = (state_d == DONE);
    pass_d = done_d && (fail_mask_d == 3'b000);
    if (busy_d) stim_d = vec_d;
    else        stim_d = 3'b000;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_q       <= 3'd0;
      cnt_q       <= 4'd0;
      stim_q      <= 3'b000;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= 3'b000;
      first_err_q <= 3'd0;
    end else begin
      vec_q       <= vec_d;
      cnt_q       <= cnt_d;
      stim_q      <= stim_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
      first_err_q <= first_err_d;
    end
  end

  assign A1 = stim_q[2];
  assign A2 = stim_q[2];
  assign A3 = stim_q[2];
  assign B1 = stim_q[1];
  assign B2 = stim_q[1];
  assign B3 = stim_q[1];
  assign C1 = stim_q[0];
  assign C2 = stim_q[0];
  assign C3 = stim_q[0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign fail_mask     = fail_mask_q;
  assign first_err_vec = first_err_q;

endmodule

// File: tb/tb_tri_nand_exerciser.sv
// Scoreboard bench: models the gates under test with selectable faults and checks
// vector order, sweep timing, results, restart handling and asynchronous reset.
module tb_tri_nand_exerciser;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic A1, B1, C1, A2, B2, C2, A3, B3, C3;
  logic Y1, Y2, Y3;
  logic busy, done, pass;
  logic [2:0] fail_mask, first_err_vec;

  int checks   = 0;
  int failures = 0;

  // 0 = good NAND, 1 = stuck-at-1, 2 = stuck-at-0, 3 = C input inverted
  logic [1:0] mode_g [3];

  typedef struct packed {
    logic       pass;
    logic [2:0] mask;
    logic [2:0] first;
  } result_t;

  result_t    exp_res_q [$];
  logic [2:0] exp_vec_q [$];

  tri_nand_exerciser #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A1(A1), .B1(B1), .C1(C1), .A2(A2), .B2(B2), .C2(C2), .A3(A3), .B3(B3), .C3(C3),
    .Y1(Y1), .Y2(Y2), .Y3(Y3),
    .busy(busy), .done(done), .pass(pass),
    .fail_mask(fail_mask), .first_err_vec(first_err_vec)
  );

  always #5 clk = ~clk;

  function automatic logic gate_fn(input logic [1:0] m, input logic a, input logic b, input logic c);
    case (m)
      2'd0:    return ~(a & b & c);
      2'd1:    return 1'b1;
      2'd2:    return 1'b0;
      default: return ~(a & b & ~c);
    endcase
  endfunction

  assign Y1 = gate_fn(mode_g[0], A1, B1, C1);
  assign Y2 = gate_fn(mode_g[1], A2, B2, C2);
  assign Y3 = gate_fn(mode_g[2], A3, B3, C3);

  function automatic logic [17:0] all_outs();
    return {A1, B1, C1, A2, B2, C2, A3, B3, C3, busy, done, pass, fail_mask, first_err_vec};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_modes(input logic [1:0] m1, input logic [1:0] m2, input logic [1:0] m3);
    mode_g[0] = m1;
    mode_g[1] = m2;
    mode_g[2] = m3;
  endtask

  // Push the expected vector order and sweep outcome for the current gate modes.
  task automatic push_expected();
    result_t    r;
    logic [2:0] fm, fe, mism, v;
    fm = 3'b000;
    fe = 3'd0;
    exp_vec_q.delete();
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      exp_vec_q.push_back(v);
      for (int g = 0; g < 3; g++) begin
        mism[g] = (gate_fn(mode_g[g], v[2], v[1], v[0]) != ~(v[2] & v[1] & v[0]));
      end
      if (fm == 3'b000 && mism != 3'b000) fe = v;
      fm = fm | mism;
    end
    r.pass  = (fm == 3'b000);
    r.mask  = fm;
    r.first = fe;
    exp_res_q.push_back(r);
  endtask

  // Run one sweep; a nonzero restart_at re-pulses start at that cycle.
  task automatic do_sweep(input string name, input int restart_at);
    int         cyc, busy_cnt, nvec;
    logic       got_done, first;
    logic [8:0] stim, last;
    logic [2:0] ev;
    result_t    r;
    push_expected();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    cyc = 0; busy_cnt = 0; nvec = 0; got_done = 1'b0; first = 1'b1; last = 9'd0;
    while (!got_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart_at);
      if (cyc == 1) begin
        check_eq({name, "_c1_done"}, 32'(done), 32'd0);
        check_eq({name, "_c1_mask"}, 32'(fail_mask), 32'd0);
      end
      if (busy) begin
        busy_cnt++;
        stim = {A1, B1, C1, A2, B2, C2, A3, B3, C3};
        if (first || stim != last) begin
          first = 1'b0;
          nvec++;
          if (exp_vec_q.size() > 0) begin
            ev = exp_vec_q.pop_front();
            check_eq({name, "_vec"}, 32'(stim), 32'({ev, ev, ev}));
          end
        end
        last = stim;
      end
      if (done) got_done = 1'b1;
    end
    start = 1'b0;
    check_eq({name, "_done_cyc"}, 32'(cyc), 32'd25);
    check_eq({name, "_busy_cnt"}, 32'(busy_cnt), 32'd24);
    check_eq({name, "_nvec"}, 32'(nvec), 32'd8);
    check_eq({name, "_stim_idle"}, 32'({A1, B1, C1, A2, B2, C2, A3, B3, C3, busy}), 32'd0);
    r = exp_res_q.pop_front();
    check_eq({name, "_pass"}, 32'(pass), 32'(r.pass));
    check_eq({name, "_mask"}, 32'(fail_mask), 32'(r.mask));
    check_eq({name, "_first"}, 32'(first_err_vec), 32'(r.first));
  endtask

  initial begin
    int guard;
    rst   = 1'b1;
    start = 1'b1;
    set_modes(2'd0, 2'd0, 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outs", 32'(all_outs()), 32'd0);
    rst   = 1'b0;
    start = 1'b0;

    do_sweep("good", 0);
    check_eq("good_pass_abs", 32'(pass), 32'd1);

    set_modes(2'd0, 2'd1, 2'd0);
    do_sweep("g2_stuck1", 0);
    check_eq("g2_mask_abs", 32'(fail_mask), 32'b010);
    check_eq("g2_first_abs", 32'(first_err_vec), 32'd7);

    set_modes(2'd0, 2'd0, 2'd0);
    do_sweep("restart_from_fail", 0);

    set_modes(2'd2, 2'd0, 2'd3);
    do_sweep("g1s0_g3cinv", 0);
    check_eq("g13_mask_abs", 32'(fail_mask), 32'b101);

    set_modes(2'd3, 2'd0, 2'd0);
    do_sweep("ignore_start", 10);

    for (int k = 0; k < 2; k++) begin
      set_modes(2'($urandom_range(3)), 2'($urandom_range(3)), 2'($urandom_range(3)));
      do_sweep("random", 0);
    end

    // Reset in the middle of a sweep while vector 4 is on the gates.
    set_modes(2'd0, 2'd0, 2'd0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!({A1, B1, C1} == 3'b100 && busy) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check_eq("reach_vec4", 32'({A1, B1, C1}), 32'b100);
    rst = 1'b1;
    #1;
    check_eq("async_rst_outs", 32'(all_outs()), 32'd0);
    start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ignores_start", 32'(all_outs()), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    do_sweep("after_rst", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
